fwd_hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage ARM pipeline (F/D/E/M/W) with dual write-back (WA3 and WA0 ports). It keeps its own shadow tags of in-flight destination registers, generates per-port forward selects for NRD execute-stage operands, handles load-use stalls and branch flushes, and adds a new multi-cycle execute mode: a long op holds E for MC_LAT cycles.

---
 rtl/hazard_pkg.sv | 41 ++++
 rtl/fwd_hazard_ctrl_if.sv | 32 +++
 rtl/hazard_tag_reg.sv | 20 ++
 rtl/fwd_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard / forwarding controller:
// forward-select codes, multi-cycle FSM states and the tag control flags.
package hazard_pkg;

    typedef enum logic [2:0] {
        FWD_RF    = 3'd0,
        FWD_RESW  = 3'd1,
        FWD_ALUM  = 3'd2,
        FWD_ALU2M = 3'd3,
        FWD_RES2W = 3'd4
    } fwd_sel_e;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

    // r15 reads the PC and is never forwarded
    localparam int unsigned PC_REG = 15;

    typedef struct packed {
        logic valid;
        logic we3;
        logic we0;
        logic load;
        logic mc;
    } tag_flags_t;

    // Younger producer (M) wins over older (W); within a stage WA3 wins over WA0
    function automatic fwd_sel_e fwd_pick(input logic m3, input logic m0,
                                          input logic w3, input logic w0);
        fwd_sel_e sel;
        if (m3)      sel = FWD_ALUM;
        else if (m0) sel = FWD_ALU2M;
        else if (w3) sel = FWD_RESW;
        else if (w0) sel = FWD_RES2W;
        else         sel = FWD_RF;
        return sel;
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-stage hazard inputs and stall/flush/forward controls between the
// pipeline datapath (master) and the hazard controller (slave).
interface fwd_hazard_ctrl_if #(
    parameter int unsigned NRD = 4,
    parameter int unsigned RW  = 4
);
    logic [NRD*RW-1:0] ra_d;
    logic [NRD-1:0]    rused_d;
    logic [RW-1:0]     wa3_d;
    logic [RW-1:0]     wa0_d;
    logic              we3_d;
    logic              we0_d;
    logic              load_d;
    logic              mc_d;
    logic              branch_taken_e;
    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              FlushD;
    logic              FlushE;
    logic [NRD*3-1:0]  ForwardE;

    modport master (
        output ra_d, rused_d, wa3_d, wa0_d, we3_d, we0_d, load_d, mc_d, branch_taken_e,
        input  StallF, StallD, StallE, FlushD, FlushE, ForwardE
    );

    modport slave (
        input  ra_d, rused_d, wa3_d, wa0_d, we3_d, we0_d, load_d, mc_d, branch_taken_e,
        output StallF, StallD, StallE, FlushD, FlushE, ForwardE
    );
endinterface

// File: rtl/hazard_tag_reg.sv
// One pipeline-stage shadow tag register: synchronous reset, synchronous
// clear (bubble insert) and hold when not enabled.
module hazard_tag_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Hazard and forwarding controller for the F/D/E/M/W pipeline with dual
// write-back; tracks in-flight destinations and holds E for multi-cycle ops.
module fwd_hazard_ctrl #(
    parameter int unsigned NRD    = 4,
    parameter int unsigned RW     = 4,
    parameter int unsigned MC_LAT = 4
) (
    input logic              clk,
    input logic              reset,
    fwd_hazard_ctrl_if.slave hif
);
    import hazard_pkg::*;

    localparam int unsigned   CW       = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MC_LAT - 1);
    localparam logic [RW-1:0] PC_ADDR  = RW'(PC_REG);

    typedef struct packed {
        tag_flags_t             f;
        logic [NRD-1:0][RW-1:0] ra;
        logic [NRD-1:0]         rused;
        logic [RW-1:0]          wa3;
        logic [RW-1:0]          wa0;
    } tag_t;

    localparam int unsigned TW = $bits(tag_t);

    tag_t             d_tag, e_q, m_q, w_q;
    mc_state_e        state;
    logic [CW-1:0]    cnt;
    logic             mc_stall, lu_hit, load_use, branch;
    logic             stall_fd, stall_e, flush_d, flush_e, e_clr;
    logic [NRD*3-1:0] fwd;
    logic             unused_w;

    always_comb begin
        d_tag         = '0;
        d_tag.f.valid = 1'b1;
        d_tag.f.we3   = hif.we3_d;
        d_tag.f.we0   = hif.we0_d;
        d_tag.f.load  = hif.load_d;
        d_tag.f.mc    = hif.mc_d;
        d_tag.ra      = hif.ra_d;
        d_tag.rused   = hif.rused_d;
        d_tag.wa3     = hif.wa3_d;
        d_tag.wa0     = hif.wa0_d;
    end

    // E gets a bubble on flush, or when D is held while E moves on
    assign e_clr = flush_e | (stall_fd & ~stall_e);

    hazard_tag_reg #(.W(TW)) u_tag_e (
        .clk   (clk),
        .reset (reset),
        .en    (~stall_e),
        .clr   (e_clr),
        .d     (d_tag),
        .q     (e_q)
    );

    hazard_tag_reg #(.W(TW)) u_tag_m (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (stall_e),
        .d     (e_q),
        .q     (m_q)
    );

    hazard_tag_reg #(.W(TW)) u_tag_w (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (1'b0),
        .d     (m_q),
        .q     (w_q)
    );

    always_comb begin
        fwd = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (e_q.f.valid && e_q.rused[i] && (e_q.ra[i] != PC_ADDR)) begin
                fwd[3*i +: 3] = fwd_pick(m_q.f.valid && m_q.f.we3 && (m_q.wa3 == e_q.ra[i]),
                                         m_q.f.valid && m_q.f.we0 && (m_q.wa0 == e_q.ra[i]),
                                         w_q.f.valid && w_q.f.we3 && (w_q.wa3 == e_q.ra[i]),
                                         w_q.f.valid && w_q.f.we0 && (w_q.wa0 == e_q.ra[i]));
            end
        end
    end

    always_comb begin
        lu_hit = 1'b0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (hif.rused_d[i] && (hif.ra_d[RW*i +: RW] == e_q.wa3)) begin
                lu_hit = 1'b1;
            end
        end
    end

    assign load_use = e_q.f.valid & e_q.f.load & e_q.f.we3 & lu_hit;

    // In IDLE this term is the first-entry cycle; the last BUSY cycle releases E
    assign mc_stall = ((state == MC_IDLE) && e_q.f.valid && e_q.f.mc && (MC_LAT > 1))
                    || ((state == MC_BUSY) && (cnt != CNT_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MC_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                MC_IDLE: begin
                    if (mc_stall) begin
                        state <= MC_BUSY;
                        cnt   <= CW'(1);
                    end
                end
                MC_BUSY: begin
                    if (cnt == CNT_LAST) begin
                        state <= MC_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= MC_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign branch   = hif.branch_taken_e;
    assign stall_fd = mc_stall | (load_use & ~branch);
    assign stall_e  = mc_stall;
    assign flush_d  = ~mc_stall & branch;
    assign flush_e  = ~mc_stall & (branch | load_use);

    assign hif.StallF   = stall_fd;
    assign hif.StallD   = stall_fd;
    assign hif.StallE   = stall_e;
    assign hif.FlushD   = flush_d;
    assign hif.FlushE   = flush_e;
    assign hif.ForwardE = fwd;

    // W only ever supplies write-back destinations
    assign unused_w = ^{w_q.ra, w_q.rused, w_q.f.load, w_q.f.mc};

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding priority, load-use,
// branch flush and multi-cycle stall sequencing, with hand-computed expectations.
module tb_fwd_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.NRD(4), .RW(4)) hif ();

    fwd_hazard_ctrl #(.NRD(4), .RW(4), .MC_LAT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic sf, input logic sd, input logic se,
                             input logic fd, input logic fe);
        check_eq({tag, ".StallF"}, 32'(hif.StallF), 32'(sf));
        check_eq({tag, ".StallD"}, 32'(hif.StallD), 32'(sd));
        check_eq({tag, ".StallE"}, 32'(hif.StallE), 32'(se));
        check_eq({tag, ".FlushD"}, 32'(hif.FlushD), 32'(fd));
        check_eq({tag, ".FlushE"}, 32'(hif.FlushE), 32'(fe));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ra, input logic [3:0] used,
                         input logic [3:0] w3, input logic e3,
                         input logic [3:0] w0, input logic e0,
                         input logic ld, input logic mc);
        hif.ra_d    = ra;
        hif.rused_d = used;
        hif.wa3_d   = w3;
        hif.we3_d   = e3;
        hif.wa0_d   = w0;
        hif.we0_d   = e0;
        hif.load_d  = ld;
        hif.mc_d    = mc;
    endtask

    task automatic nop();
        drive(16'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        hif.branch_taken_e = 1'b0;
        nop();
        repeat (3) tick();
    endtask

    // older producer ends in W, newer in M, consumer in E
    task automatic run_seq(input string tag,
                           input int unsigned o3, input int unsigned oe3,
                           input int unsigned o0, input int unsigned oe0,
                           input int unsigned n3, input int unsigned ne3,
                           input int unsigned n0, input int unsigned ne0,
                           input int unsigned cra, input int unsigned cused,
                           input int unsigned cp, input int unsigned exp);
        logic [11:0] fe;
        drain();
        drive(16'h0, 4'h0, 4'(o3), 1'(oe3), 4'(o0), 1'(oe0), 1'b0, 1'b0);
        tick();
        drive(16'h0, 4'h0, 4'(n3), 1'(ne3), 4'(n0), 1'(ne0), 1'b0, 1'b0);
        tick();
        drive(16'(cra) << (4*cp), 4'(cused) << cp, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        nop();
        #1;
        fe = hif.ForwardE;
        check_eq(tag, 32'(fe[3*cp +: 3]), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        hif.branch_taken_e = 1'b0;
        nop();
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst.ForwardE", 32'(hif.ForwardE), 32'd0);
        check_eq("rst.m_valid", 32'(dut.m_q.f.valid), 32'd0);

        run_seq("fwd_m_wa3",  0, 0, 0, 0,   1, 1, 0, 0,   1, 1, 0, 2);
        run_seq("fwd_w_wa3",  1, 1, 0, 0,   0, 0, 0, 0,   1, 1, 0, 1);
        run_seq("fwd_m_wa0",  0, 0, 0, 0,   0, 0, 1, 1,   1, 1, 1, 3);
        run_seq("fwd_w_wa0",  0, 0, 1, 1,   0, 0, 0, 0,   1, 1, 1, 4);
        run_seq("m_over_w",   3, 1, 0, 0,   3, 1, 0, 0,   3, 1, 2, 2);
        run_seq("m0_over_w3", 3, 1, 0, 0,   0, 0, 3, 1,   3, 1, 0, 3);
        run_seq("w3_over_w0", 5, 1, 5, 1,   0, 0, 0, 0,   5, 1, 3, 1);
        run_seq("we3_off",    0, 0, 0, 0,   1, 0, 0, 0,   1, 1, 0, 0);
        run_seq("pc_reg",     0, 0, 0, 0,  15, 1, 0, 0,  15, 1, 0, 0);
        run_seq("rused_off",  0, 0, 0, 0,   1, 1, 0, 0,   1, 0, 0, 0);
        run_seq("no_match",   0, 0, 0, 0,   2, 1, 0, 0,   1, 1, 0, 0);

        // LDR r4 ; ADD r5, r4
        drain();
        drive(16'h0, 4'h0, 4'd4, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(16'h0004, 4'b0001, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check_ctl("lu", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        #1;
        check_ctl("lu_next", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        nop();
        #1;
        check_eq("lu_fwd", 32'(hif.ForwardE[2:0]), 32'd1);

        // load-use detection on an unused port and on the top port
        drain();
        drive(16'h0, 4'h0, 4'd4, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(16'h0004, 4'b0000, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("lu_unused.StallF", 32'(hif.StallF), 32'd0);
        drive(16'h4000, 4'b1000, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("lu_port3.StallF", 32'(hif.StallF), 32'd1);

        // taken branch overrides load-use
        drain();
        drive(16'h0, 4'h0, 4'd4, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(16'h0004, 4'b0001, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        hif.branch_taken_e = 1'b1;
        #1;
        check_ctl("br_lu", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        hif.branch_taken_e = 1'b0;

        // multi-cycle op writing r6, consumer of r6 waiting in D
        drain();
        drive(16'h0, 4'h0, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(16'h0006, 4'b0001, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check_ctl("mc_c0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        hif.branch_taken_e = 1'b1;
        #1;
        check_ctl("mc_c0_br", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        hif.branch_taken_e = 1'b0;
        tick();
        check_eq("mc_m1.valid", 32'(dut.m_q.f.valid), 32'd0);
        check_ctl("mc_c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("mc_m2.valid", 32'(dut.m_q.f.valid), 32'd0);
        check_ctl("mc_c2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("mc_m3.valid", 32'(dut.m_q.f.valid), 32'd0);
        check_ctl("mc_c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("mc_m4.valid", 32'(dut.m_q.f.valid), 32'd1);
        check_eq("mc_m4.mc", 32'(dut.m_q.f.mc), 32'd1);
        check_eq("mc_fwd", 32'(hif.ForwardE[2:0]), 32'd2);
        check_eq("mc_after.StallE", 32'(hif.StallE), 32'd0);

        // reset during BUSY aborts the op
        drain();
        drive(16'h0, 4'h0, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        nop();
        #1;
        check_eq("mr_c0.StallE", 32'(hif.StallE), 32'd1);
        tick();
        check_eq("mr_c1.StallE", 32'(hif.StallE), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_ctl("mr_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_ctl("mr_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
